// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller and its
// 2-bit direction predictor.
package branch_resolve_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_FLUSH    = 2'd2
   } state_e;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   // Instructions are word aligned, so the predictor index starts at PC bit 2.
   localparam int IDX_LSB = 2;

   function automatic int idx_msb(input int idx_w);
      return idx_w + IDX_LSB - 1;
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Fetch/EX/redirect signal bundle; master is the controller, slave the pipeline.
interface branch_resolve_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);
   logic [XLEN-1:0]  if_pc;
   logic             if_pred_taken;
   logic             ex_valid;
   logic             ex_branch;
   logic [XLEN-1:0]  ex_pc;
   logic             ex_pred_taken;
   logic             ex_taken;
   logic [XLEN-1:0]  ex_target;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             redirect_ready;
   logic             stall_ex;
   logic             flush;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      input  if_pc, ex_valid, ex_branch, ex_pc, ex_pred_taken, ex_taken,
             ex_target, redirect_ready,
      output if_pred_taken, redirect_valid, redirect_pc, stall_ex, flush,
             mispredict_cnt
   );

   modport slave (
      output if_pc, ex_valid, ex_branch, ex_pc, ex_pred_taken, ex_taken,
             ex_target, redirect_ready,
      input  if_pred_taken, redirect_valid, redirect_pc, stall_ex, flush,
             mispredict_cnt
   );
endinterface

// File: rtl/branch_resolve_ctrl_bht_2bit.sv
// Direct-mapped table of 2-bit saturating counters: one combinational read
// port, one synchronous saturating update port.
module bht_2bit
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   localparam int ENTRIES = 2 ** IDX_W;

   logic [1:0] cnt_q [ENTRIES];
   logic [1:0] cur_cnt;
   logic [1:0] upd_cnt;

   // No write-to-read bypass: a same-cycle lookup sees the old counter.
   assign rd_taken_o = cnt_q[rd_idx_i][1];
   assign cur_cnt    = cnt_q[wr_idx_i];

   always_comb begin
      upd_cnt = cur_cnt;
      if (wr_taken_i && (cur_cnt != CNT_ST)) begin
         upd_cnt = cur_cnt + 2'd1;
      end else if (!wr_taken_i && (cur_cnt != CNT_SNT)) begin
         upd_cnt = cur_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= CNT_WNT;
         end
      end else if (wr_en_i) begin
         cnt_q[wr_idx_i] <= upd_cnt;
      end
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves EX-stage conditional branches: trains the predictor, and on a
// mispredict issues a handshaked fetch redirect followed by a fixed flush.
//
//  state       | meaning
//  ST_IDLE     | accepting resolves; outputs quiet
//  ST_REDIRECT | redirect_valid held until fetch accepts; EX stalled, flush high
//  ST_FLUSH    | flush high for FLUSH_CYCLES cycles after acceptance; EX runs
module branch_resolve_ctrl
   import branch_resolve_ctrl_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int IDX_W        = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   branch_resolve_ctrl_if.master bus
);

   localparam int IDX_MSB = idx_msb(IDX_W);
   localparam int FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  rpc_q, rpc_d;
   logic             rvalid_q, rvalid_d;
   logic             stall_q, stall_d;
   logic             flush_q, flush_d;
   logic [CNT_W-1:0] mcnt_q, mcnt_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;

   logic resolve;
   logic mispredict;
   logic unused_pc_bits;

   assign resolve    = bus.ex_valid && bus.ex_branch && (state_q == ST_IDLE);
   assign mispredict = resolve && (bus.ex_taken != bus.ex_pred_taken);

   assign unused_pc_bits = ^{bus.if_pc[XLEN-1:IDX_MSB+1], bus.if_pc[IDX_LSB-1:0]};

   bht_2bit #(
      .IDX_W (IDX_W)
   ) u_bht (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx_i   (bus.if_pc[IDX_MSB:IDX_LSB]),
      .rd_taken_o (bus.if_pred_taken),
      .wr_en_i    (resolve),
      .wr_idx_i   (bus.ex_pc[IDX_MSB:IDX_LSB]),
      .wr_taken_i (bus.ex_taken)
   );

   always_comb begin
      state_d  = state_q;
      rpc_d    = rpc_q;
      rvalid_d = rvalid_q;
      stall_d  = stall_q;
      flush_d  = flush_q;
      mcnt_d   = mcnt_q;
      fcnt_d   = fcnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (mispredict) begin
               rpc_d    = bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
               rvalid_d = 1'b1;
               stall_d  = 1'b1;
               flush_d  = 1'b1;
               if (mcnt_q != {CNT_W{1'b1}}) begin
                  mcnt_d = mcnt_q + CNT_W'(1);
               end
               state_d  = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            if (rvalid_q && bus.redirect_ready) begin
               rvalid_d = 1'b0;
               stall_d  = 1'b0;
               fcnt_d   = FC_W'(FLUSH_CYCLES - 1);
               state_d  = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (fcnt_q == '0) begin
               flush_d = 1'b0;
               state_d = ST_IDLE;
            end else begin
               fcnt_d = fcnt_q - FC_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rpc_q    <= '0;
         rvalid_q <= 1'b0;
         stall_q  <= 1'b0;
         flush_q  <= 1'b0;
         mcnt_q   <= '0;
         fcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         rpc_q    <= rpc_d;
         rvalid_q <= rvalid_d;
         stall_q  <= stall_d;
         flush_q  <= flush_d;
         mcnt_q   <= mcnt_d;
         fcnt_q   <= fcnt_d;
      end
   end

   assign bus.redirect_valid = rvalid_q;
   assign bus.redirect_pc    = rpc_q;
   assign bus.stall_ex       = stall_q;
   assign bus.flush          = flush_q;
   assign bus.mispredict_cnt = mcnt_q;

endmodule
